// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the pattern generator and checker.
// Holds the width, tap mask, checker state type and the one-step function.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    // x^8 + x^6 + x^5 + x^4 + 1 : feedback from bits 7,5,4,3
    localparam logic [LFSR_W-1:0] TAPS = 8'hB8;

    typedef enum logic {
        SEARCH,
        LOCKED
    } chk_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] cur
    );
        return {cur[LFSR_W-2:0], ^(cur & TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Word stream and status bundle between an LFSR source and the checker.
// master: drives in_valid/in_data/clr_cnt; slave: drives locked/err_pulse/err_cnt.
interface lfsr_checker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid,
        output in_data,
        output clr_cnt,
        input  locked,
        input  err_pulse,
        input  err_cnt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  clr_cnt,
        output locked,
        output err_pulse,
        output err_cnt
    );

endinterface

// File: rtl/lfsr_err_counter.sv
// Saturating error counter with synchronous clear.
// Ports: clk, rst (async, active-high), clr_i, inc_i, cnt_o[CNT_W].
module lfsr_err_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A clear coinciding with an increment still counts that increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CNT_W'(inc_i);
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS sink for the 8-bit LFSR generator.
// Ports: clk, rst (async, active-high), bus (slave: stream in, lock/error status out).
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH      = LFSR_W,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    lfsr_checker_if.slave  bus
);

    localparam int GW = $clog2(LOCK_CNT + 2);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    localparam logic [GW-1:0] G_ONE  = GW'(1);
    localparam logic [GW-1:0] G_LOCK = GW'(LOCK_CNT);
    localparam logic [BW-1:0] B_ONE  = BW'(1);
    localparam logic [BW-1:0] B_LAST = BW'(UNLOCK_CNT - 1);

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [GW-1:0]    good_q, good_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic             locked_q;
    logic             pulse_q, pulse_d;
    logic             inc;
    logic             hit;

    assign hit = (bus.in_data == exp_q);

    // good_q is 1 right after a seed word, so it equals the number of
    // confirmed predictions plus one; LOCK_CNT matches are needed to lock.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        good_d  = good_q;
        bad_d   = bad_q;
        pulse_d = 1'b0;
        inc     = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (bus.in_data == '0) begin
                        good_d = '0;
                    end else begin
                        exp_d = lfsr_step(bus.in_data);
                        if (hit && (good_q != '0)) begin
                            good_d = good_q + G_ONE;
                            if (good_q == G_LOCK) begin
                                state_d = LOCKED;
                                bad_d   = '0;
                            end
                        end else begin
                            good_d = G_ONE;
                        end
                    end
                end
                LOCKED: begin
                    // Free-run from the local copy so a bad word cannot
                    // knock the prediction out of alignment.
                    exp_d = lfsr_step(exp_q);
                    if (hit) begin
                        bad_d = '0;
                    end else begin
                        pulse_d = 1'b1;
                        inc     = 1'b1;
                        bad_d   = bad_q + B_ONE;
                        if (bad_q == B_LAST) begin
                            state_d = SEARCH;
                            good_d  = '0;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEARCH;
            exp_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked_q <= (state_d == LOCKED);
            pulse_q  <= pulse_d;
        end
    end

    lfsr_err_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.clr_cnt),
        .inc_i (inc),
        .cnt_o (bus.err_cnt)
    );

    assign bus.locked    = locked_q;
    assign bus.err_pulse = pulse_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised self-checking bench for lfsr_checker.
// Two instances: default 16-bit counter and a 3-bit counter for saturation.
module tb_lfsr_checker;

    logic clk;
    logic rst;

    lfsr_checker_if #(.WIDTH(8), .CNT_W(16)) if_a ();
    lfsr_checker_if #(.WIDTH(8), .CNT_W(3))  if_b ();

    lfsr_checker #(.CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    lfsr_checker #(.CNT_W(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    // Reference model: state kept as plain counts.
    bit       m_lock;
    bit       m_seeded;
    int       m_match;
    int       m_miss;
    bit [7:0] m_exp;
    bit       m_pulse;
    int       m_cnt_a;
    int       m_cnt_b;
    bit [7:0] g_cur;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [7:0] mstep(input bit [7:0] c);
        bit [7:0] n;
        n = {c[6:0], 1'b0};
        if ($countones(c & 8'hB8) % 2 == 1) n[0] = 1'b1;
        return n;
    endfunction

    function automatic int sat_inc(input int c, input int mx, input bit clr,
                                   input bit inc);
        if (clr) return inc ? 1 : 0;
        if (inc && c < mx) return c + 1;
        return c;
    endfunction

    task automatic model_reset();
        m_lock   = 0;
        m_seeded = 0;
        m_match  = 0;
        m_miss   = 0;
        m_exp    = 8'h00;
        m_pulse  = 0;
        m_cnt_a  = 0;
        m_cnt_b  = 0;
    endtask

    task automatic model_upd(input bit v, input bit [7:0] w, input bit clr);
        bit err;
        err = 0;
        if (v) begin
            if (!m_lock) begin
                if (w == 0) begin
                    m_seeded = 0;
                end else begin
                    if (m_seeded && w == m_exp) begin
                        m_match++;
                        if (m_match == 4) begin
                            m_lock = 1;
                            m_miss = 0;
                        end
                    end else begin
                        m_seeded = 1;
                        m_match  = 0;
                    end
                    m_exp = mstep(w);
                end
            end else begin
                err   = (w != m_exp);
                m_exp = mstep(m_exp);
                if (!err) begin
                    m_miss = 0;
                end else begin
                    m_miss++;
                    if (m_miss == 3) begin
                        m_lock   = 0;
                        m_seeded = 0;
                        m_match  = 0;
                    end
                end
            end
        end
        m_pulse = err;
        m_cnt_a = sat_inc(m_cnt_a, 65535, clr, err);
        m_cnt_b = sat_inc(m_cnt_b, 7, clr, err);
    endtask

    task automatic cmp_all();
        chk("locked_a", 32'(if_a.locked), 32'(m_lock));
        chk("pulse_a", 32'(if_a.err_pulse), 32'(m_pulse));
        chk("cnt_a", 32'(if_a.err_cnt), 32'(m_cnt_a));
        chk("locked_b", 32'(if_b.locked), 32'(m_lock));
        chk("pulse_b", 32'(if_b.err_pulse), 32'(m_pulse));
        chk("cnt_b", 32'(if_b.err_cnt), 32'(m_cnt_b));
    endtask

    task automatic drive(input bit v, input bit [7:0] d, input bit clr);
        if_a.in_valid = v;
        if_a.in_data  = d;
        if_a.clr_cnt  = clr;
        if_b.in_valid = v;
        if_b.in_data  = d;
        if_b.clr_cnt  = clr;
        @(posedge clk);
        #1;
        model_upd(v, d, clr);
        cmp_all();
    endtask

    // Generator-side helpers: every sent word consumes one generator step.
    task automatic send_good();
        drive(1, g_cur, 0);
        g_cur = mstep(g_cur);
    endtask

    task automatic send_bad(input bit clr);
        bit [7:0] x;
        x = 8'($urandom_range(1, 255));
        drive(1, g_cur ^ x, clr);
        g_cur = mstep(g_cur);
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        cmp_all();
    endtask

    task automatic lock_from_reset();
        do_reset();
        g_cur = 8'h01;
        repeat (5) send_good();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1;
        g_cur = 8'h01;
        if_a.in_valid = 0;
        if_a.in_data  = 0;
        if_a.clr_cnt  = 0;
        if_b.in_valid = 0;
        if_b.in_data  = 0;
        if_b.clr_cnt  = 0;
        model_reset();
        #1;
        cmp_all();

        // 1: seed 01 then four matches lock the checker.
        do_reset();
        drive(1, 8'h01, 0);
        drive(1, 8'h02, 0);
        drive(1, 8'h04, 0);
        drive(1, 8'h08, 0);
        chk("t1_not_yet", 32'(if_a.locked), 32'd0);
        drive(1, 8'h11, 0);
        chk("t1_locked", 32'(if_a.locked), 32'd1);
        chk("t1_cnt", 32'(if_a.err_cnt), 32'd0);

        // 2: single corrupted word while locked.
        drive(1, 8'h00, 0);
        chk("t2_pulse", 32'(if_a.err_pulse), 32'd1);
        chk("t2_cnt", 32'(if_a.err_cnt), 32'd1);
        chk("t2_locked", 32'(if_a.locked), 32'd1);
        drive(1, 8'h47, 0);
        chk("t2_nopulse", 32'(if_a.err_pulse), 32'd0);
        g_cur = mstep(8'h47);

        // 3: three consecutive bad words unlock; clean stream relocks.
        repeat (3) send_bad(0);
        chk("t3_unlock", 32'(if_a.locked), 32'd0);
        chk("t3_cnt", 32'(if_a.err_cnt), 32'd4);
        repeat (4) send_good();
        chk("t3_still_search", 32'(if_a.locked), 32'd0);
        send_good();
        chk("t3_relock", 32'(if_a.locked), 32'd1);

        // 4: idle gaps must not advance the prediction.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) drive(0, 8'($urandom), 0);
            else send_good();
        end
        chk("t4_locked", 32'(if_a.locked), 32'd1);
        chk("t4_cnt", 32'(if_a.err_cnt), 32'd4);

        // 5: all-zero stream never locks; then saturate the small counter.
        do_reset();
        repeat (12) drive(1, 8'h00, 0);
        chk("t5_zero_lock", 32'(if_a.locked), 32'd0);
        chk("t5_zero_cnt", 32'(if_a.err_cnt), 32'd0);
        g_cur = 8'h5A;
        repeat (5) send_good();
        for (int i = 0; i < 6; i++) begin
            send_bad(0);
            send_bad(0);
            send_good();
        end
        chk("t5_sat_b", 32'(if_b.err_cnt), 32'd7);
        chk("t5_cnt_a", 32'(if_a.err_cnt), 32'd12);

        // 6: asynchronous reset while locked with five errors counted.
        lock_from_reset();
        for (int i = 0; i < 5; i++) begin
            send_bad(0);
            send_good();
        end
        chk("t6_pre_cnt", 32'(if_a.err_cnt), 32'd5);
        chk("t6_pre_lock", 32'(if_a.locked), 32'd1);
        rst = 1;
        #1;
        chk("t6_rst_lock", 32'(if_a.locked), 32'd0);
        chk("t6_rst_cnt", 32'(if_a.err_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 0;
        g_cur = 8'h01;
        repeat (5) send_good();
        send_bad(0);
        send_bad(1);
        chk("t6_clr_inc", 32'(if_a.err_cnt), 32'd1);
        chk("t6_clr_lock", 32'(if_a.locked), 32'd1);

        // Random mix of clean, corrupt, zero and idle words.
        do_reset();
        g_cur = 8'($urandom_range(1, 255));
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit c;
            r = int'($urandom_range(0, 99));
            c = ($urandom_range(0, 99) < 3);
            if (r < 15) begin
                drive(0, 8'($urandom), c);
            end else if (r < 22) begin
                send_bad(c);
            end else if (r < 25) begin
                drive(1, 8'h00, c);
                g_cur = mstep(g_cur);
            end else begin
                drive(1, g_cur, c);
                g_cur = mstep(g_cur);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
